// File: rtl/draw_line_gen.sv
// draw_line_gen: integer Bresenham rasteriser for a single line or a closed triangle
// outline, streaming one pixel per valid/ready transfer with a last-pixel flag.
module draw_line_gen #(
    parameter int COORD_W = 8
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               START,
    input  logic               MODE,
    input  logic [COORD_W-1:0] X_0,
    input  logic [COORD_W-1:0] Y_0,
    input  logic [COORD_W-1:0] X_1,
    input  logic [COORD_W-1:0] Y_1,
    input  logic [COORD_W-1:0] X_2,
    input  logic [COORD_W-1:0] Y_2,
    output logic               BUSY,
    output logic [COORD_W-1:0] X_Out,
    output logic [COORD_W-1:0] Y_Out,
    output logic               PIX_VALID,
    input  logic               PIX_READY,
    output logic               PIX_LAST,
    output logic               finish
);
    localparam int DW = COORD_W + 2;

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;
    state_t state_reg, state_next;

    logic [COORD_W-1:0] in_x [3];
    logic [COORD_W-1:0] in_y [3];
    logic [2:0]         in_nz;
    logic [COORD_W-1:0] vx_reg [3];
    logic [COORD_W-1:0] vy_reg [3];
    logic [2:0]         mask_reg;      // edges still to draw; lowest set bit is the current edge
    logic               incl_end_reg;  // emit the end vertex of the edge (line mode / degenerate triangle)
    logic [1:0]         cur_idx, nxt_idx;
    logic [2:0]         mask_rem;
    logic [COORD_W-1:0] ax, ay, bx, by, adx, ady, max_d, setup_rem;
    logic [COORD_W-1:0] x_reg, y_reg, rem_reg, x_step, y_step;
    logic               sx_neg_reg, sy_neg_reg;
    logic signed [DW-1:0] dx_reg, dy_reg, err_reg, setup_dx, setup_dy, err_step;
    logic signed [DW:0]   e2, dx_w, dy_w;
    logic               step_x, step_y, xfer, edge_end;

    assign in_x[0] = X_0;
    assign in_x[1] = X_1;
    assign in_x[2] = X_2;
    assign in_y[0] = Y_0;
    assign in_y[1] = Y_1;
    assign in_y[2] = Y_2;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge_nz
            localparam int NI = (gi + 1) % 3;
            assign in_nz[gi] = (in_x[gi] != in_x[NI]) || (in_y[gi] != in_y[NI]);
        end
    endgenerate

    always_comb begin
        cur_idx = 2'd2;
        nxt_idx = 2'd0;
        if (mask_reg[0]) begin
            cur_idx = 2'd0;
            nxt_idx = 2'd1;
        end else if (mask_reg[1]) begin
            cur_idx = 2'd1;
            nxt_idx = 2'd2;
        end
    end

    assign mask_rem = mask_reg & ~(3'b001 << cur_idx);

    assign ax = vx_reg[cur_idx];
    assign ay = vy_reg[cur_idx];
    assign bx = vx_reg[nxt_idx];
    assign by = vy_reg[nxt_idx];
    assign adx = (bx > ax) ? bx - ax : ax - bx;
    assign ady = (by > ay) ? by - ay : ay - by;
    assign max_d = (adx >= ady) ? adx : ady;
    // Each step moves the major axis by one, so the pixel count is known up front.
    assign setup_rem = incl_end_reg ? max_d : max_d - COORD_W'(1);
    assign setup_dx = $signed({2'b00, adx});
    assign setup_dy = -$signed({2'b00, ady});

    assign e2     = {err_reg, 1'b0};
    assign dx_w   = {dx_reg[DW-1], dx_reg};
    assign dy_w   = {dy_reg[DW-1], dy_reg};
    assign step_x = (e2 >= dy_w);
    assign step_y = (e2 <= dx_w);
    assign err_step = err_reg + (step_x ? dy_reg : DW'(0)) + (step_y ? dx_reg : DW'(0));
    assign x_step = sx_neg_reg ? x_reg - COORD_W'(1) : x_reg + COORD_W'(1);
    assign y_step = sy_neg_reg ? y_reg - COORD_W'(1) : y_reg + COORD_W'(1);
    assign xfer     = (state_reg == RUN) && PIX_READY;
    assign edge_end = (rem_reg == '0);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        BUSY       = 1'b0;
        PIX_VALID  = 1'b0;
        PIX_LAST   = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: if (START) state_next = SETUP;
            SETUP: begin
                BUSY       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                BUSY      = 1'b1;
                PIX_VALID = 1'b1;
                PIX_LAST  = edge_end && (mask_rem == 3'b000);
                if (PIX_READY && edge_end)
                    state_next = (mask_rem != 3'b000) ? SETUP : DONE;
            end
            DONE: begin
                BUSY       = 1'b1;
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 3; i++) begin
                vx_reg[i] <= '0;
                vy_reg[i] <= '0;
            end
            mask_reg     <= '0;
            incl_end_reg <= 1'b0;
            x_reg        <= '0;
            y_reg        <= '0;
            rem_reg      <= '0;
            sx_neg_reg   <= 1'b0;
            sy_neg_reg   <= 1'b0;
            dx_reg       <= '0;
            dy_reg       <= '0;
            err_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: if (START) begin
                    for (int i = 0; i < 3; i++) begin
                        vx_reg[i] <= in_x[i];
                        vy_reg[i] <= in_y[i];
                    end
                    // A triangle with no non-zero edge collapses to a one-pixel "line" V0->V1.
                    if (!MODE || (in_nz == 3'b000)) begin
                        mask_reg     <= 3'b001;
                        incl_end_reg <= 1'b1;
                    end else begin
                        mask_reg     <= in_nz;
                        incl_end_reg <= 1'b0;
                    end
                end
                SETUP: begin
                    x_reg      <= ax;
                    y_reg      <= ay;
                    dx_reg     <= setup_dx;
                    dy_reg     <= setup_dy;
                    err_reg    <= setup_dx + setup_dy;
                    sx_neg_reg <= !(bx > ax);
                    sy_neg_reg <= !(by > ay);
                    rem_reg    <= setup_rem;
                end
                RUN: if (xfer) begin
                    if (edge_end) begin
                        mask_reg <= mask_rem;
                    end else begin
                        err_reg <= err_step;
                        rem_reg <= rem_reg - COORD_W'(1);
                        if (step_x) x_reg <= x_step;
                        if (step_y) y_reg <= y_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign X_Out = x_reg;
    assign Y_Out = y_reg;
endmodule

// File: tb/tb_draw_line_gen.sv
// Testbench for draw_line_gen: directed and random jobs on 8-bit and 12-bit instances,
// compared against a textbook Bresenham pixel-list model with cycle-level handshake checks.
module tb_draw_line_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, mode, ready, sel;
    logic [15:0] x0, y0, x1, y1, x2, y2;

    logic        busy8, valid8, last8, fin8;
    logic [7:0]  xo8, yo8;
    logic        busy12, valid12, last12, fin12;
    logic [11:0] xo12, yo12;

    logic        o_busy, o_valid, o_last, o_fin;
    logic [15:0] o_x, o_y;

    draw_line_gen #(.COORD_W(8)) dut8 (
        .ACLK(clk), .ARESETN(rst_n), .START(start && !sel), .MODE(mode),
        .X_0(x0[7:0]), .Y_0(y0[7:0]), .X_1(x1[7:0]), .Y_1(y1[7:0]),
        .X_2(x2[7:0]), .Y_2(y2[7:0]),
        .BUSY(busy8), .X_Out(xo8), .Y_Out(yo8), .PIX_VALID(valid8),
        .PIX_READY(ready), .PIX_LAST(last8), .finish(fin8)
    );

    draw_line_gen #(.COORD_W(12)) dut12 (
        .ACLK(clk), .ARESETN(rst_n), .START(start && sel), .MODE(mode),
        .X_0(x0[11:0]), .Y_0(y0[11:0]), .X_1(x1[11:0]), .Y_1(y1[11:0]),
        .X_2(x2[11:0]), .Y_2(y2[11:0]),
        .BUSY(busy12), .X_Out(xo12), .Y_Out(yo12), .PIX_VALID(valid12),
        .PIX_READY(ready), .PIX_LAST(last12), .finish(fin12)
    );

    always_comb begin
        o_busy  = sel ? busy12  : busy8;
        o_valid = sel ? valid12 : valid8;
        o_last  = sel ? last12  : last8;
        o_fin   = sel ? fin12   : fin8;
        o_x     = sel ? {4'b0, xo12} : {8'b0, xo8};
        o_y     = sel ? {4'b0, yo12} : {8'b0, yo8};
    end

    int n_tests = 0;
    int n_fail  = 0;
    int jx [3];
    int jy [3];
    int ex_x [$];
    int ex_y [$];
    int ex_edges;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Textbook all-octant Bresenham: walk until the end point is reached.
    task automatic plot(input int ax, input int ay, input int bx, input int by, input bit incl);
        int x, y, dx, dy, sx, sy, err, e2, guard;
        x = ax; y = ay;
        dx = (bx > ax) ? bx - ax : ax - bx;
        dy = -((by > ay) ? by - ay : ay - by);
        sx = (ax < bx) ? 1 : -1;
        sy = (ay < by) ? 1 : -1;
        err = dx + dy;
        guard = 0;
        while (!(x == bx && y == by) && guard < 70000) begin
            ex_x.push_back(x);
            ex_y.push_back(y);
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
            guard++;
        end
        if (incl) begin
            ex_x.push_back(bx);
            ex_y.push_back(by);
        end
    endtask

    task automatic model(input bit m);
        int b;
        ex_x.delete();
        ex_y.delete();
        ex_edges = 0;
        for (int e = 0; e < (m ? 3 : 1); e++) begin
            b = (e + 1) % 3;
            if (!(m && jx[e] == jx[b] && jy[e] == jy[b])) begin
                ex_edges++;
                plot(jx[e], jy[e], jx[b], jy[b], !m);
            end
        end
        if (m && ex_edges == 0) begin
            ex_x.push_back(jx[0]);
            ex_y.push_back(jy[0]);
            ex_edges = 1;
        end
    endtask

    task automatic job(input bit tsel, input bit m, input bit rnd,
                       input int xa, input int ya, input int xb, input int yb,
                       input int xc, input int yc);
        int cycle, got, n, budget, last_xfer, first_valid;
        bit stall, done;
        logic [15:0] hx, hy;
        logic hl;
        jx[0] = xa; jy[0] = ya; jx[1] = xb; jy[1] = yb; jx[2] = xc; jy[2] = yc;
        model(m);
        n = ex_x.size();
        budget = 4 * (n + ex_edges) + 20;
        sel = tsel;
        @(negedge clk);
        check("idle_busy", o_busy, 0);
        x0 = 16'(xa); y0 = 16'(ya); x1 = 16'(xb); y1 = 16'(yb); x2 = 16'(xc); y2 = 16'(yc);
        mode = m;
        start = 1'b1;
        ready = rnd ? 1'($urandom % 2) : 1'b1;
        cycle = 0; got = 0; last_xfer = -1; first_valid = -1;
        stall = 0; done = 0; hx = '0; hy = '0; hl = 1'b0;
        while (!done) begin
            @(negedge clk);
            cycle++;
            if (cycle > budget) begin
                check("timeout", cycle, budget);
                start = 1'b0;
                break;
            end
            // Stray requests and input churn while busy must be ignored.
            start = rnd ? ($urandom % 4 == 0) : 1'b0;
            if (rnd) begin
                mode = 1'($urandom % 2);
                x0 = 16'($urandom); y0 = 16'($urandom); x1 = 16'($urandom); y1 = 16'($urandom);
            end
            if (cycle == 1) begin
                check("c1_busy", o_busy, 1);
                check("c1_valid", o_valid, 0);
            end
            if (stall) begin
                check("stall_x", o_x, hx);
                check("stall_y", o_y, hy);
                check("stall_last", o_last, hl);
            end
            ready = rnd ? 1'($urandom % 2) : 1'b1;
            if (o_valid) begin
                if (first_valid < 0) first_valid = cycle;
                if (ready) begin
                    if (got < n) begin
                        check("pix_x", o_x, ex_x[got]);
                        check("pix_y", o_y, ex_y[got]);
                        check("pix_last", o_last, (got == n - 1));
                        $display("[TB] w%0d pix %0d (%0d,%0d) last=%0d cyc=%0d",
                                 tsel ? 12 : 8, got, o_x, o_y, o_last, cycle);
                    end else begin
                        check("extra_pix", got, n - 1);
                    end
                    got++;
                    last_xfer = cycle;
                end
                stall = !ready;
                hx = o_x; hy = o_y; hl = o_last;
            end else begin
                stall = 0;
            end
            if (o_fin) begin
                check("fin_cycle", cycle, last_xfer + 1);
                check("pix_count", got, n);
                check("first_valid", first_valid, 2);
                check("fin_busy", o_busy, 1);
                if (!rnd) check("job_len", cycle + 1, n + ex_edges + 2);
                start = 1'b0;
                @(negedge clk);
                check("post_busy", o_busy, 0);
                check("post_fin", o_fin, 0);
                $display("[TB] job w%0d mode=%0d pixels=%0d edges=%0d cycles=%0d",
                         tsel ? 12 : 8, m, got, ex_edges, cycle + 1);
                done = 1;
            end
        end
        ready = 1'b1;
    endtask

    task automatic reset_test();
        jx[0] = 0; jy[0] = 0; jx[1] = 200; jy[1] = 100; jx[2] = 0; jy[2] = 0;
        model(1'b0);
        sel = 1'b0;
        @(negedge clk);
        x0 = 16'd0; y0 = 16'd0; x1 = 16'd200; y1 = 16'd100;
        mode = 1'b0; start = 1'b1; ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("rst_pre_valid", o_valid, 1);
        check("rst_pre_x", o_x, ex_x[2]);
        check("rst_pre_y", o_y, ex_y[2]);
        rst_n = 1'b0;
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_x", o_x, 0);
        check("rst_y", o_y, 0);
        @(posedge clk);
        #1;
        check("rst_hold_fin", o_fin, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_after", {o_busy, o_fin, o_valid}, 3'b000);
        end
        $display("[TB] reset mid-job done");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; ready = 1'b1; sel = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        #1;
        check("reset_state8", {busy8, valid8, last8, fin8, xo8, yo8}, '0);
        check("reset_state12", {busy12, valid12, last12, fin12, xo12, yo12}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        job(0, 0, 0, 1, 5, 0, 0, 0, 0);
        job(0, 1, 0, 0, 0, 3, 0, 0, 3);
        job(0, 0, 0, 2, 2, 9, 6, 0, 0);
        job(0, 0, 1, 2, 2, 9, 6, 0, 0);
        job(0, 0, 0, 7, 7, 7, 7, 0, 0);
        job(0, 1, 0, 4, 4, 4, 4, 4, 4);
        job(0, 1, 0, 0, 0, 0, 0, 5, 0);
        job(0, 0, 0, 0, 0, 255, 255, 0, 0);
        job(0, 0, 1, 255, 0, 0, 255, 0, 0);
        job(1, 0, 0, 0, 4095, 4095, 0, 0, 0);
        reset_test();
        job(0, 1, 0, 0, 0, 3, 0, 0, 3);

        for (int k = 0; k < 16; k++) begin
            job(0, 1'($urandom % 2), 1'($urandom % 2),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        for (int k = 0; k < 3; k++) begin
            job(1, 1'($urandom % 2), 1'($urandom % 2),
                int'($urandom_range(3968, 4095)), int'($urandom_range(3968, 4095)),
                int'($urandom_range(3968, 4095)), int'($urandom_range(3968, 4095)),
                int'($urandom_range(3968, 4095)), int'($urandom_range(3968, 4095)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/draw_line_gen.md
# draw_line_gen

Parametrised successor to the fixed 8-bit line drawer. It rasterises either a single line (V0→V1) or a closed triangle outline (V0→V1→V2→V0) using integer Bresenham in all octants, with configurable coordinate width. Pixels leave on a valid/ready stream with backpressure, a last-pixel flag, and a start/busy/finish job handshake. It sits between the command decoder and the framebuffer write port.

## Interface
- COORD_W, 8, coordinate width in bits (unsigned), legal range 4..16.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- START  in  1  job request; accepted only while BUSY=0.
- MODE  in  1  0 = line V0→V1; 1 = triangle outline.
- X_0, Y_0, X_1, Y_1, X_2, Y_2  in  COORD_W each  vertices; sampled only on the accept cycle. V2 is ignored when MODE=0.
- BUSY  out  1  high from the cycle after accept through the cycle that FINISH is high.
- X_Out, Y_Out  out  COORD_W each  current pixel.
- PIX_VALID  out  1  pixel available.
- PIX_READY  in  1  sink accepts the pixel.
- PIX_LAST  out  1  current pixel is the final pixel of the job; qualified by PIX_VALID.
- finish  out  1  one-cycle pulse at job end.

## Operation
- Reset values: BUSY, PIX_VALID, PIX_LAST and finish are 0. X_Out and Y_Out are 0. FSM is in IDLE. All internal registers are cleared.
- FSM states: IDLE, SETUP, RUN, DONE.
- IDLE: when START=1, latch MODE and vertices, set edge index to 0, go to SETUP. START while BUSY=1 is ignored (not queued).
- SETUP (1 cycle) loads the current edge endpoints (A, B):
  - x=Ax, y=Ay, dx=|Bx−Ax|, dy=−|By−Ay|.
  - sx=+1 if Bx>Ax, else −1; sy likewise.
  - err=dx+dy.
  - dx, dy and err are signed, COORD_W+2 bits wide. No overflow is possible.
- RUN: PIX_VALID=1 with X_Out=x, Y_Out=y. A transfer is PIX_VALID&&PIX_READY. On each transfer:
  - If the current pixel is the edge's final emitted pixel, end the edge.
  - Otherwise step: e2=2·err. If e2≥dy, then err+=dy and x+=sx. If e2≤dx, then err+=dx and y+=sy. Both updates can apply in the same step.
- Pixels emitted per edge:
  - Line mode: both endpoints are emitted, giving max(|dx|,|dy|)+1 pixels.
  - Triangle mode: each edge excludes its end vertex, giving max(|dx|,|dy|) pixels. Zero-length edges are skipped entirely with no SETUP cycle spent in RUN.
  - Triangle mode with all three edges zero-length: emit V0 exactly once.
- Edge end: if more edges remain, go to SETUP for the next edge. Otherwise go to DONE.
- PIX_LAST is 1 only on the final pixel of the whole job.
- DONE: finish=1 for one cycle, then IDLE. BUSY drops together with the return to IDLE.
- Backpressure: while PIX_VALID=1 and PIX_READY=0, X_Out, Y_Out and PIX_LAST hold stable and no internal state advances.
- X_Out and Y_Out retain their last value outside RUN.
- Coordinates never leave the range [0, 2^COORD_W−1]. The stepper never steps beyond the endpoint.

## Timing
- Accept at cycle 0 (START=1 in IDLE). BUSY=1 and SETUP at cycle 1. First PIX_VALID at cycle 2.
- With PIX_READY held at 1, one pixel is transferred per cycle.
- Between triangle edges there is exactly one bubble cycle (SETUP) with PIX_VALID=0.
- finish pulses in the cycle after the last transfer. The earliest next accept is the cycle after finish.
- Job length with PIX_READY=1 is N pixels + (number of non-skipped edges) + 2 cycles, where the +2 covers the accept and DONE cycles.
- Asynchronous ARESETN assertion mid-job immediately forces the reset values. The aborted job is lost, and no finish or PIX_LAST is produced for it.

## Test plan
- COORD_W=8, line (1,5)→(0,0), PIX_READY=1 → pixels (1,5),(1,4),(1,3),(0,2),(0,1),(0,0) on cycles 2..7; PIX_LAST on (0,0); finish on cycle 8.
- Triangle (0,0),(3,0),(0,3) → (0,0),(1,0),(2,0), bubble, (3,0),(2,1),(1,2), bubble, (0,3),(0,2),(0,1); 9 pixels; PIX_LAST on (0,1); each pixel appears exactly once.
- Line (2,2)→(9,6) with PIX_READY toggling pseudo-randomly → the same 8-pixel sequence as with READY=1; outputs stable during every stall; START pulses during BUSY are ignored.
- Degenerate cases: line (7,7)→(7,7) gives one pixel (7,7) with PIX_LAST; triangle with all vertices (4,4) gives one pixel (4,4); triangle (0,0),(0,0),(5,0) gives 10 pixels ending at (1,0).
- Range extremes: COORD_W=8, (0,0)→(255,255) gives 256 diagonal pixels ending at (255,255); (255,0)→(0,255) gives 256 pixels with no wrap. Rerun with COORD_W=12 for (0,4095)→(4095,0).
- Reset: ARESETN low for 1 cycle at the 3rd pixel of a long line → all outputs 0 immediately, no finish; a new START afterwards runs correctly from SETUP.
